pipeline_mem_stage: RTL and testbench
=====================================

Name: pipeline_mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, directly downstream of the EX stage.
- Consumes EX's registered ALU result, store data, rd and write-back controls.
- Performs loads and stores over a req/ack data-memory port, with byte-lane alignment, sign/zero extension and a bounded-wait timeout.
- Registers the results into the MEM/WB boundary and raises a pipeline stall while an access is outstanding.

Parameters:
- XLEN, 64, datapath width.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before the access is aborted; range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alu_result_EX  in  64  effective address, or value for non-memory instructions
- reg_data2_MEM  in  64  store data
- rd_MEM  in  5  destination register
- pc_MEM  in  64  instruction PC
- rf_wr_en_EX  in  1  register-file write enable
- rf_wr_sel_EX  in  2  write-back source select; passed through unchanged
- dm_rd_ctrl_EX  in  3  load type
- dm_wr_ctrl_EX  in  3  store type
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  64  doubleword-aligned address {alu_result_EX[63:3], 3'b000}
- dmem_wdata  out  64  lane-shifted store data
- dmem_wstrb  out  8  byte strobes
- dmem_rdata  in  64  read doubleword; valid when dmem_ack = 1
- dmem_ack  in  1  access complete; may assert in the same cycle as dmem_req
- stall_MEM  out  1  freeze IF/ID/EX pipeline registers
- alu_result_WB  out  64  registered alu_result_EX
- mem_rdata_WB  out  64  registered aligned and extended load data
- pc_WB  out  64  registered PC
- rd_WB  out  5  registered destination register
- rf_wr_en_WB  out  1  registered write enable
- rf_wr_sel_WB  out  2  registered write-back select
- mem_err_WB  out  2  0 = none, 1 = misaligned, 2 = timeout, 3 = illegal (load and store both set)

Behaviour:
- Load encodings: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD.
- Store encodings: 0 none, 1 SB, 2 SH, 3 SW, 4 SD; values 5..7 are treated as none.
- access = (rd_ctrl != 0) XOR (wr_ctrl != 0), with no error condition present.
- Error conditions:
  - misaligned: halfword with addr[0] = 1, word with addr[1:0] != 0, doubleword with addr[2:0] != 0.
  - illegal: both load and store controls nonzero.
- Erroring instructions issue no request and complete in 1 cycle as a bubble: rf_wr_en_WB = 0, with mem_err_WB set for that one cycle.
- FSM states: IDLE, WAIT.
- IDLE:
  - dmem_req = access, driven combinationally.
  - If access and dmem_ack: complete in this cycle, 0 stall.
  - If access and !dmem_ack: go to WAIT, counter = 1.
- WAIT:
  - dmem_req = 1; address, data, strobes and dmem_we stay constant, from stable held inputs.
  - On dmem_ack: complete and return to IDLE.
  - Otherwise, if counter == TIMEOUT_CYCLES: abort, go to IDLE, bubble with mem_err_WB = 2, dmem_req drops the next cycle.
  - Otherwise: counter + 1.
- stall_MEM = dmem_req & !dmem_ack & !timeout_abort.
- Upstream stages must hold their registers, including EX's outputs, while stall_MEM = 1.
- WB register update, every clock:
  - Stall cycle: load a bubble (rf_wr_en_WB = 0, rd_WB = 0, mem_err_WB = 0).
  - Completion or non-memory cycle: latch all pass-through fields.
- Load alignment, from lane = alu_result_EX[2:0]:
  - Byte = rdata[8*lane +: 8], halfword = rdata[8*lane +: 16], word = rdata[8*lane +: 32].
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD takes all 64 bits.
  - mem_rdata_WB = 0 for non-loads.
- Store formatting:
  - dmem_wdata = data replicated to the access size, shifted left by 8*lane.
  - Strobes: SB 8'b1 << lane, SH 8'b11 << lane, SW 8'hF << lane, SD 8'hFF.
  - dmem_wstrb = 0 when not a store.
- Reset (synchronous, reset = 1 at a clk edge):
  - FSM goes to IDLE, counter = 0.
  - All *_WB outputs = 0.
  - dmem_req, dmem_we, dmem_wstrb and stall_MEM are forced to 0 while reset = 1.
  - Reset during WAIT abandons the access; a late dmem_ack after reset is ignored.
- A dmem_ack with no request outstanding is ignored.

Decomposition:
- Shared header pipeline_defs.vh holds:
  - load and store encodings (LD_* / ST_*);
  - mem_err codes;
  - FSM state localparams.
- Sub-module mem_lane_align (combinational) takes lane, rd_ctrl, wr_ctrl, store data and rdata, and produces wdata, wstrb, extended load data and the misalign flag.
- The FSM, timeout counter and WB registers stay in pipeline_mem_stage.

Test Plan:
- LB at addr 0x1003, rdata 0x00000000_80000000 with same-cycle ack → mem_rdata_WB = 0xFFFFFFFF_FFFFFF80, no stall, rf_wr_en_WB = 1 the next cycle.
- SH at addr 0x2006, data 0xABCD, ack after 3 cycles → dmem_wstrb = 8'hC0, dmem_wdata[63:48] = 0xABCD, stall_MEM = 1 for exactly 3 cycles, WB holds bubbles during them, completion on the 4th cycle.
- LW at addr 0x1002 → no dmem_req, mem_err_WB = 1 for one cycle, rf_wr_en_WB = 0.
- Load with ack never asserted, TIMEOUT_CYCLES = 4 → stall for 4 cycles, then mem_err_WB = 2, dmem_req = 0 the next cycle.
- Reset asserted in WAIT, then dmem_ack the following cycle → all outputs 0, state IDLE, no WB write.
- ADD (both ctrls 0, alu_result 0x55, rd = 7) → WB latches 0x55 and rd 7 the next cycle, with no dmem_req.

Source files
------------

// File: rtl/pipeline_mem_stage_pkg.sv
// pipeline_mem_stage_pkg: load/store encodings, error codes, FSM states and access-size helpers
package pipeline_mem_stage_pkg;
    localparam logic [2:0] LD_NONE = 3'd0, LD_LB = 3'd1, LD_LBU = 3'd2, LD_LH = 3'd3,
                           LD_LHU = 3'd4, LD_LW = 3'd5, LD_LWU = 3'd6, LD_LD = 3'd7;
    localparam logic [2:0] ST_NONE = 3'd0, ST_SB = 3'd1, ST_SH = 3'd2, ST_SW = 3'd3, ST_SD = 3'd4;

    typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL} mem_err_e;
    typedef enum logic {S_IDLE, S_WAIT} state_e;

    // Access size as log2(bytes): 0 byte, 1 half, 2 word, 3 double
    function automatic logic [1:0] ld_size(input logic [2:0] c);
        return c == LD_LD ? 2'd3 : c >= LD_LW ? 2'd2 : c >= LD_LH ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] st_size(input logic [2:0] c);
        return c == ST_SD ? 2'd3 : c == ST_SW ? 2'd2 : c == ST_SH ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/pipeline_mem_stage_if.sv
// pipeline_mem_stage_if: data-memory req/ack port
interface pipeline_mem_stage_if #(parameter int XLEN = 64);
    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN/8-1:0] dmem_wstrb;
    logic [XLEN-1:0]   dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/pipeline_mem_stage_lane_align.sv
// mem_lane_align: byte-lane store formatting, load extraction/extension and misalignment detection
module mem_lane_align
    import pipeline_mem_stage_pkg::*;
(
    input  logic [2:0]  lane_i,
    input  logic [2:0]  rd_ctrl_i,
    input  logic [2:0]  wr_ctrl_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [63:0] wdata_o,
    output logic [7:0]  wstrb_o,
    output logic [63:0] ld_data_o,
    output logic        misalign_o
);
    logic       is_ld, is_st;
    logic [1:0] sz;
    logic [5:0] sh;
    logic [63:0] rep, rs;

    assign is_ld = rd_ctrl_i != LD_NONE;
    assign is_st = wr_ctrl_i != ST_NONE && wr_ctrl_i <= ST_SD;
    assign sz    = is_st ? st_size(wr_ctrl_i) : ld_size(rd_ctrl_i);
    assign sh    = {lane_i, 3'b000};

    assign misalign_o = (is_ld | is_st) &
                        (sz == 2'd1 ? lane_i[0] : sz == 2'd2 ? |lane_i[1:0] : sz == 2'd3 ? |lane_i : 1'b0);

    assign rep = sz == 2'd0 ? {8{wdata_i[7:0]}} :
                 sz == 2'd1 ? {4{wdata_i[15:0]}} :
                 sz == 2'd2 ? {2{wdata_i[31:0]}} : wdata_i;

    assign wdata_o = is_st ? rep << sh : '0;
    assign wstrb_o = !is_st ? 8'h00 : sz == 2'd3 ? 8'hFF :
                     (sz == 2'd2 ? 8'h0F : sz == 2'd1 ? 8'h03 : 8'h01) << lane_i;

    assign rs = rdata_i >> sh;
    assign ld_data_o = rd_ctrl_i == LD_LB  ? {{56{rs[7]}}, rs[7:0]} :
                       rd_ctrl_i == LD_LBU ? {56'd0, rs[7:0]} :
                       rd_ctrl_i == LD_LH  ? {{48{rs[15]}}, rs[15:0]} :
                       rd_ctrl_i == LD_LHU ? {48'd0, rs[15:0]} :
                       rd_ctrl_i == LD_LW  ? {{32{rs[31]}}, rs[31:0]} :
                       rd_ctrl_i == LD_LWU ? {32'd0, rs[31:0]} :
                       rd_ctrl_i == LD_LD  ? rdata_i : '0;
endmodule

// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage: MEM stage with req/ack data port, timeout, stall generation and MEM/WB registers
module pipeline_mem_stage
    import pipeline_mem_stage_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_result_EX,
    input  logic [XLEN-1:0] reg_data2_MEM,
    input  logic [4:0]      rd_MEM,
    input  logic [XLEN-1:0] pc_MEM,
    input  logic            rf_wr_en_EX,
    input  logic [1:0]      rf_wr_sel_EX,
    input  logic [2:0]      dm_rd_ctrl_EX,
    input  logic [2:0]      dm_wr_ctrl_EX,
    pipeline_mem_stage_if.master dmem,
    output logic            stall_MEM,
    output logic [XLEN-1:0] alu_result_WB,
    output logic [XLEN-1:0] mem_rdata_WB,
    output logic [XLEN-1:0] pc_WB,
    output logic [4:0]      rd_WB,
    output logic            rf_wr_en_WB,
    output logic [1:0]      rf_wr_sel_WB,
    output logic [1:0]      mem_err_WB
);
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_ld, is_st, misalign, access, req, timeout_abort;
    mem_err_e    err;
    logic [XLEN-1:0] ld_data, wdata;
    logic [7:0]  wstrb;

    mem_lane_align u_align (
        .lane_i     (alu_result_EX[2:0]),
        .rd_ctrl_i  (dm_rd_ctrl_EX),
        .wr_ctrl_i  (dm_wr_ctrl_EX),
        .wdata_i    (reg_data2_MEM),
        .rdata_i    (dmem.dmem_rdata),
        .wdata_o    (wdata),
        .wstrb_o    (wstrb),
        .ld_data_o  (ld_data),
        .misalign_o (misalign)
    );

    assign is_ld  = dm_rd_ctrl_EX != LD_NONE;
    assign is_st  = dm_wr_ctrl_EX != ST_NONE && dm_wr_ctrl_EX <= ST_SD;
    assign err    = (is_ld & is_st) ? ERR_ILLEGAL : misalign ? ERR_MISALIGN : ERR_NONE;
    assign access = (is_ld ^ is_st) & (err == ERR_NONE);

    // WAIT keeps requesting from the held EX inputs; reset silences the port
    assign req           = !reset & (state_q == S_WAIT | access);
    assign timeout_abort = state_q == S_WAIT & !dmem.dmem_ack & cnt_q == 16'(TIMEOUT_CYCLES);
    assign stall_MEM     = req & !dmem.dmem_ack & !timeout_abort;

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & is_st;
    assign dmem.dmem_addr  = {alu_result_EX[XLEN-1:3], 3'b000};
    assign dmem.dmem_wdata = wdata;
    assign dmem.dmem_wstrb = reset ? 8'h00 : wstrb;

    // Next state: enter WAIT on an unacknowledged access, leave on ack or timeout; counter tracks WAIT cycles
    always_comb begin
        state_d = state_q == S_IDLE ? (access & !dmem.dmem_ack ? S_WAIT : S_IDLE) :
                  (dmem.dmem_ack | timeout_abort ? S_IDLE : S_WAIT);
        cnt_d   = state_d == S_WAIT ? cnt_q + 16'd1 : 16'd0;
    end

    // FSM state and timeout counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB boundary: bubble while stalled, otherwise latch results; errors and timeouts suppress the write
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_WB <= '0;
            mem_rdata_WB  <= '0;
            pc_WB         <= '0;
            rd_WB         <= '0;
            rf_wr_en_WB   <= 1'b0;
            rf_wr_sel_WB  <= '0;
            mem_err_WB    <= '0;
        end else if (stall_MEM) begin
            rd_WB         <= '0;
            rf_wr_en_WB   <= 1'b0;
            mem_err_WB    <= '0;
        end else begin
            alu_result_WB <= alu_result_EX;
            mem_rdata_WB  <= (is_ld & access & !timeout_abort) ? ld_data : '0;
            pc_WB         <= pc_MEM;
            rd_WB         <= rd_MEM;
            rf_wr_en_WB   <= rf_wr_en_EX & (err == ERR_NONE) & !timeout_abort;
            rf_wr_sel_WB  <= rf_wr_sel_EX;
            mem_err_WB    <= timeout_abort ? ERR_TIMEOUT : err;
        end
    end
endmodule

// File: tb/tb_pipeline_mem_stage.sv
// tb_pipeline_mem_stage: scoreboard bench for the MEM stage (TIMEOUT_CYCLES = 4)
module tb_pipeline_mem_stage;
    import pipeline_mem_stage_pkg::*;

    typedef struct packed {
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [1:0]  err;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] alu_result_EX = '0, reg_data2_MEM = '0, pc_MEM = 64'h8000_0000;
    logic [4:0]  rd_MEM = '0;
    logic        rf_wr_en_EX = 1'b0;
    logic [1:0]  rf_wr_sel_EX = '0;
    logic [2:0]  dm_rd_ctrl_EX = '0, dm_wr_ctrl_EX = '0;
    logic        stall_MEM;
    logic [63:0] alu_result_WB, mem_rdata_WB, pc_WB;
    logic [4:0]  rd_WB;
    logic        rf_wr_en_WB;
    logic [1:0]  rf_wr_sel_WB, mem_err_WB;

    int  checks = 0;
    int  errors = 0;
    wb_t exp_q[$];
    wb_t e;
    wb_t wb_now;

    pipeline_mem_stage_if #(.XLEN(64)) bus ();

    pipeline_mem_stage #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_result_EX (alu_result_EX),
        .reg_data2_MEM (reg_data2_MEM),
        .rd_MEM        (rd_MEM),
        .pc_MEM        (pc_MEM),
        .rf_wr_en_EX   (rf_wr_en_EX),
        .rf_wr_sel_EX  (rf_wr_sel_EX),
        .dm_rd_ctrl_EX (dm_rd_ctrl_EX),
        .dm_wr_ctrl_EX (dm_wr_ctrl_EX),
        .dmem          (bus),
        .stall_MEM     (stall_MEM),
        .alu_result_WB (alu_result_WB),
        .mem_rdata_WB  (mem_rdata_WB),
        .pc_WB         (pc_WB),
        .rd_WB         (rd_WB),
        .rf_wr_en_WB   (rf_wr_en_WB),
        .rf_wr_sel_WB  (rf_wr_sel_WB),
        .mem_err_WB    (mem_err_WB)
    );

    assign wb_now = {alu_result_WB, mem_rdata_WB, pc_WB, rd_WB, rf_wr_en_WB, rf_wr_sel_WB, mem_err_WB};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int nb_ld(input logic [2:0] c);
        case (c)
            LD_LB, LD_LBU: return 1;
            LD_LH, LD_LHU: return 2;
            LD_LW, LD_LWU: return 4;
            LD_LD:         return 8;
            default:       return 0;
        endcase
    endfunction

    function automatic int nb_st(input logic [2:0] c);
        case (c)
            ST_SB:   return 1;
            ST_SH:   return 2;
            ST_SW:   return 4;
            ST_SD:   return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] c, input logic [2:0] lane, input logic [63:0] rd);
        logic [63:0] v = '0;
        int n = nb_ld(c);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(int'(lane) + i) +: 8];
        if ((c == LD_LB || c == LD_LH || c == LD_LW) && v[8*n-1])
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [2:0] c, input logic [2:0] lane, input logic [63:0] d);
        logic [63:0] w = '0;
        int n = nb_st(c);
        for (int i = int'(lane); i < 8; i++) w[8*i +: 8] = d[8*((i - int'(lane)) % n) +: 8];
        return w;
    endfunction

    function automatic logic [7:0] m_strb(input logic [2:0] c, input logic [2:0] lane);
        logic [7:0] s = '0;
        for (int i = 0; i < nb_st(c); i++) if (int'(lane) + i < 8) s[int'(lane) + i] = 1'b1;
        return s;
    endfunction

    function automatic wb_t mk(input logic [63:0] rdata, input logic we, input logic [1:0] err);
        return {alu_result_EX, rdata, pc_MEM, rd_MEM, we, rf_wr_sel_EX, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] rc, input logic [2:0] wc, input logic [63:0] a,
                         input logic [63:0] d, input logic [4:0] r, input logic we);
        dm_rd_ctrl_EX = rc;
        dm_wr_ctrl_EX = wc;
        alu_result_EX = a;
        reg_data2_MEM = d;
        rd_MEM        = r;
        rf_wr_en_EX   = we;
        rf_wr_sel_EX  = r[1:0];
        pc_MEM        = pc_MEM + 64'd4;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(LD_LW, ST_SD, 64'h100, 64'h1234, 5'd3, 1'b1);
        tick();
        drive(3'd0, ST_SW, 64'h100, 64'h1234, 5'd3, 1'b1);
        #1;
        checks++;
        if ({bus.dmem_req, bus.dmem_we, stall_MEM, bus.dmem_wstrb} !== 11'd0) begin
            errors++;
            $display("FAIL reset_port got %b exp 0", {bus.dmem_req, bus.dmem_we, stall_MEM, bus.dmem_wstrb});
        end
        tick();
        checks++;
        if (wb_now !== '0) begin
            errors++;
            $display("FAIL reset_wb got %h exp 0", wb_now);
        end
        reset = 1'b0;
        drive(3'd0, 3'd0, 64'h0, 64'h0, 5'd0, 1'b0);
    endtask

    task automatic test_alu();
        logic [63:0] av [2] = '{64'h55, 64'hDEAD_BEEF_0123_4567};
        logic [4:0]  rv [2] = '{5'd7, 5'd31};
        for (int i = 0; i < 2; i++) begin
            drive(3'd0, 3'd0, av[i], 64'h9999, rv[i], 1'b1);
            bus.dmem_ack = (i == 1);
            #1;
            checks++;
            if ({bus.dmem_req, stall_MEM} !== 2'b00) begin
                errors++;
                $display("FAIL alu_req got %b exp 00", {bus.dmem_req, stall_MEM});
            end
            exp_q.push_back(mk(64'd0, 1'b1, ERR_NONE));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (wb_now !== e) begin
                errors++;
                $display("FAIL alu_wb got %h exp %h", wb_now, e);
            end
        end
        bus.dmem_ack = 1'b0;
    endtask

    task automatic test_load();
        logic [2:0]  lc [7] = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW, LD_LWU, LD_LD};
        logic [63:0] la [7] = '{64'h1003, 64'h1005, 64'h1006, 64'h1002, 64'h1004, 64'h1000, 64'h1008};
        for (int i = 0; i < 7; i++) begin
            drive(lc[i], 3'd0, la[i], 64'h0, 5'(i + 1), 1'b1);
            bus.dmem_rdata = (i == 0) ? 64'h0000_0000_8000_0000 : 64'hF1E2_D3C4_B5A6_9788;
            bus.dmem_ack = 1'b1;
            #1;
            checks++;
            if ({bus.dmem_req, bus.dmem_we, stall_MEM, bus.dmem_addr} !== {3'b100, la[i][63:3], 3'b000}) begin
                errors++;
                $display("FAIL load_port got %h exp %h", {bus.dmem_req, bus.dmem_we, stall_MEM, bus.dmem_addr},
                         {3'b100, la[i][63:3], 3'b000});
            end
            exp_q.push_back(mk(m_load(lc[i], la[i][2:0], bus.dmem_rdata), 1'b1, ERR_NONE));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (wb_now !== e) begin
                errors++;
                $display("FAIL load_wb got %h exp %h", wb_now, e);
            end
            if (i == 0) begin
                checks++;
                if (mem_rdata_WB !== 64'hFFFF_FFFF_FFFF_FF80) begin
                    errors++;
                    $display("FAIL lb_sext got %h exp ffffffffffffff80", mem_rdata_WB);
                end
            end
        end
        bus.dmem_ack = 1'b0;
    endtask

    task automatic test_store();
        logic [2:0]  sc [3] = '{ST_SB, ST_SW, ST_SD};
        logic [63:0] sa [3] = '{64'h3003, 64'h3004, 64'h3000};
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, sc[i], sa[i], 64'h0123_4567_89AB_CD5A, 5'd0, 1'b0);
            bus.dmem_ack = 1'b1;
            #1;
            checks++;
            if ({bus.dmem_req, bus.dmem_we, stall_MEM, bus.dmem_wstrb, bus.dmem_wdata} !==
                {3'b110, m_strb(sc[i], sa[i][2:0]), m_wdata(sc[i], sa[i][2:0], reg_data2_MEM)}) begin
                errors++;
                $display("FAIL store_port got %h exp %h", {bus.dmem_req, bus.dmem_we, stall_MEM, bus.dmem_wstrb, bus.dmem_wdata},
                         {3'b110, m_strb(sc[i], sa[i][2:0]), m_wdata(sc[i], sa[i][2:0], reg_data2_MEM)});
            end
            exp_q.push_back(mk(64'd0, 1'b0, ERR_NONE));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (wb_now !== e) begin
                errors++;
                $display("FAIL store_wb got %h exp %h", wb_now, e);
            end
        end
        bus.dmem_ack = 1'b0;
    endtask

    task automatic test_store_wait();
        drive(3'd0, ST_SH, 64'h2006, 64'h0000_0000_0000_ABCD, 5'd9, 1'b0);
        bus.dmem_ack = 1'b0;
        #1;
        checks++;
        if (bus.dmem_wstrb !== 8'hC0 || bus.dmem_wdata[63:48] !== 16'hABCD || bus.dmem_we !== 1'b1) begin
            errors++;
            $display("FAIL sh_format got strb %h data %h we %b exp c0 abcd 1", bus.dmem_wstrb, bus.dmem_wdata, bus.dmem_we);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({stall_MEM, bus.dmem_req, bus.dmem_addr, bus.dmem_wstrb} !== {2'b11, 64'h2000, 8'hC0}) begin
                errors++;
                $display("FAIL sh_wait%0d got %h exp 3_0000000000002000_c0", c, {stall_MEM, bus.dmem_req, bus.dmem_addr, bus.dmem_wstrb});
            end
            tick();
            checks++;
            if ({rf_wr_en_WB, rd_WB, mem_err_WB} !== 8'd0) begin
                errors++;
                $display("FAIL sh_bubble%0d got %h exp 0", c, {rf_wr_en_WB, rd_WB, mem_err_WB});
            end
        end
        bus.dmem_ack = 1'b1;
        #1;
        checks++;
        if ({stall_MEM, bus.dmem_req} !== 2'b01) begin
            errors++;
            $display("FAIL sh_ack got %b exp 01", {stall_MEM, bus.dmem_req});
        end
        exp_q.push_back(mk(64'd0, 1'b0, ERR_NONE));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (wb_now !== e) begin
            errors++;
            $display("FAIL sh_wb got %h exp %h", wb_now, e);
        end
        bus.dmem_ack = 1'b0;
    endtask

    task automatic test_errors();
        logic [2:0]  rc [4] = '{LD_LW, 3'd0, LD_LB, 3'd0};
        logic [2:0]  wc [4] = '{3'd0, ST_SD, ST_SB, 3'd0};
        logic [63:0] ad [4] = '{64'h1002, 64'h2004, 64'h1000, 64'h66};
        logic [1:0]  ec [4] = '{ERR_MISALIGN, ERR_MISALIGN, ERR_ILLEGAL, ERR_NONE};
        for (int i = 0; i < 4; i++) begin
            drive(rc[i], wc[i], ad[i], 64'h42, 5'(i + 4), 1'b1);
            bus.dmem_ack = 1'b0;
            #1;
            checks++;
            if ({bus.dmem_req, stall_MEM} !== 2'b00) begin
                errors++;
                $display("FAIL err_req%0d got %b exp 00", i, {bus.dmem_req, stall_MEM});
            end
            exp_q.push_back(mk(64'd0, ec[i] == ERR_NONE, ec[i]));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (wb_now !== e) begin
                errors++;
                $display("FAIL err_wb%0d got %h exp %h", i, wb_now, e);
            end
        end
    endtask

    task automatic test_timeout();
        drive(LD_LD, 3'd0, 64'h4000, 64'h0, 5'd5, 1'b1);
        bus.dmem_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({stall_MEM, bus.dmem_req} !== 2'b11) begin
                errors++;
                $display("FAIL to_stall%0d got %b exp 11", c, {stall_MEM, bus.dmem_req});
            end
            tick();
        end
        #1;
        checks++;
        if ({stall_MEM, bus.dmem_req} !== 2'b01) begin
            errors++;
            $display("FAIL to_abort got %b exp 01", {stall_MEM, bus.dmem_req});
        end
        exp_q.push_back(mk(64'd0, 1'b0, ERR_TIMEOUT));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (wb_now !== e) begin
            errors++;
            $display("FAIL to_wb got %h exp %h", wb_now, e);
        end
        drive(3'd0, 3'd0, 64'h88, 64'h0, 5'd2, 1'b1);
        #1;
        checks++;
        if ({stall_MEM, bus.dmem_req} !== 2'b00) begin
            errors++;
            $display("FAIL to_drop got %b exp 00", {stall_MEM, bus.dmem_req});
        end
        exp_q.push_back(mk(64'd0, 1'b1, ERR_NONE));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (wb_now !== e) begin
            errors++;
            $display("FAIL to_next_wb got %h exp %h", wb_now, e);
        end
    endtask

    task automatic test_reset_in_wait();
        drive(LD_LW, 3'd0, 64'h5000, 64'h0, 5'd6, 1'b1);
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 64'h1111_2222_3333_4444;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.dmem_req, bus.dmem_we, stall_MEM, bus.dmem_wstrb} !== 11'd0) begin
            errors++;
            $display("FAIL rw_port got %b exp 0", {bus.dmem_req, bus.dmem_we, stall_MEM, bus.dmem_wstrb});
        end
        tick();
        bus.dmem_ack = 1'b1;
        #1;
        checks++;
        if ({bus.dmem_req, stall_MEM} !== 2'b00) begin
            errors++;
            $display("FAIL rw_ack_in_reset got %b exp 00", {bus.dmem_req, stall_MEM});
        end
        tick();
        checks++;
        if (wb_now !== '0) begin
            errors++;
            $display("FAIL rw_wb got %h exp 0", wb_now);
        end
        reset = 1'b0;
        drive(3'd0, 3'd0, 64'h77, 64'h0, 5'd0, 1'b0);
        #1;
        checks++;
        if ({bus.dmem_req, stall_MEM} !== 2'b00) begin
            errors++;
            $display("FAIL rw_late_ack got %b exp 00", {bus.dmem_req, stall_MEM});
        end
        exp_q.push_back(mk(64'd0, 1'b0, ERR_NONE));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (wb_now !== e) begin
            errors++;
            $display("FAIL rw_late_wb got %h exp %h", wb_now, e);
        end
        bus.dmem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_store_wait();
        test_errors();
        test_timeout();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
